// File: rtl/fifo_dual_port_pkg.sv
// Shared sizing rules and parameter legality checks for the dual-port FIFO.
// The helpers are constant functions, so they can size ports and localparams.
package fifo_dual_port_pkg;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // The count needs one more bit than a pointer, because it must hold DEPTH itself.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit almost_full_th_ok(input int th, input int depth);
    return (th >= 1) && (th <= depth);
  endfunction

  function automatic bit almost_empty_th_ok(input int th, input int depth);
    return (th >= 0) && (th <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_dual_port_dual_port_ram.sv
// Storage for the FIFO: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module dual_port_ram #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset, so it can map onto RAM macros; the
  // non-blocking write is also what makes a same-slot read return the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  dout <= '0;
    else if (re) dout <= mem[raddr];
  end

endmodule

// File: rtl/fifo_dual_port.sv
// Single-clock FIFO with occupancy count, full/empty and almost flags,
// and one-cycle overflow/underflow pulses. All outputs are registered.
module fifo_dual_port
  import fifo_dual_port_pkg::*;
#(
  parameter int DATA_WIDTH      = 6,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  Clock,
  input  logic                  iReset_n,
  input  logic                  iPush,
  input  logic [DATA_WIDTH-1:0] iDataIn,
  input  logic                  iPop,
  output logic [DATA_WIDTH-1:0] oDataOut,
  output logic                  oValid,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAlmostFull,
  output logic                  oAlmostEmpty,
  output logic                  oOverflow,
  output logic                  oUnderflow
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CW    = count_width(ADDR_WIDTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_TH);

  if (!almost_full_th_ok(ALMOST_FULL_TH, DEPTH)) begin : g_bad_af_th
    $fatal(1, "fifo_dual_port: ALMOST_FULL_TH=%0d outside 1..%0d", ALMOST_FULL_TH, DEPTH);
  end
  if (!almost_empty_th_ok(ALMOST_EMPTY_TH, DEPTH)) begin : g_bad_ae_th
    $fatal(1, "fifo_dual_port: ALMOST_EMPTY_TH=%0d outside 0..%0d", ALMOST_EMPTY_TH, DEPTH - 1);
  end

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [CW-1:0]         count, count_next;
  logic                  push_ok, pop_ok;

  // A pop while full frees the slot the simultaneous push lands in.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    pop_ok     = iPop & ~oEmpty;
    push_ok    = iPush & (~oFull | iPop);
    count_next = count;
    if (push_ok && !pop_ok)      count_next = count + CW'(1);
    else if (pop_ok && !push_ok) count_next = count - CW'(1);
  end

  dual_port_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (Clock),
    .rst_n(iReset_n),
    .we   (push_ok),
    .waddr(wptr),
    .din  (iDataIn),
    .re   (pop_ok),
    .raddr(rptr),
    .dout (oDataOut)
  );

  // Flags are registered from the next count, so they line up with oCount.
  always_ff @(posedge Clock or negedge iReset_n) begin
    if (!iReset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      oValid       <= 1'b0;
      oOverflow    <= 1'b0;
      oUnderflow   <= 1'b0;
      oFull        <= 1'b0;
      oEmpty       <= 1'b1;
      oAlmostFull  <= (ALMOST_FULL_TH == 0);
      oAlmostEmpty <= 1'b1;
    end else begin
      if (push_ok) wptr <= wptr + ADDR_WIDTH'(1);
      if (pop_ok)  rptr <= rptr + ADDR_WIDTH'(1);
      count        <= count_next;
      oValid       <= pop_ok;
      oOverflow    <= iPush & ~push_ok;
      oUnderflow   <= iPop & ~pop_ok;
      oFull        <= (count_next == DEPTH_C);
      oEmpty       <= (count_next == '0);
      oAlmostFull  <= (count_next >= AF_TH);
      oAlmostEmpty <= (count_next <= AE_TH);
    end
  end

  assign oCount = count;

endmodule

// File: doc/fifo_dual_port.md
Name: fifo_dual_port

Overview:
- Synchronous single-clock FIFO built on a parametrised dual-port memory: one write port and one registered read port.
- Next generation of the team's dual-port memory. Adds push/pop handshake, occupancy count, full/empty and programmable almost-flags, and overflow/underflow error pulses.
- Sits between producer and consumer stages as an elastic buffer.

Parameters:
- DATA_WIDTH, 6, width of each stored word.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (default 8 entries).
- ALMOST_FULL_TH, 6, oAlmostFull asserted when count >= this value; legal range 1..DEPTH.
- ALMOST_EMPTY_TH, 2, oAlmostEmpty asserted when count <= this value; legal range 0..DEPTH-1.

Ports:
- Clock  input  1  single clock, rising edge.
- iReset_n  input  1  asynchronous, active-low reset.
- iPush  input  1  write request; iDataIn is sampled on the same edge.
- iDataIn  input  DATA_WIDTH  write data.
- iPop  input  1  read request.
- oDataOut  output  DATA_WIDTH  read data, registered.
- oValid  output  1  oDataOut holds data from a pop accepted on the previous edge.
- oCount  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- oFull  output  1  count == DEPTH.
- oEmpty  output  1  count == 0.
- oAlmostFull  output  1  count >= ALMOST_FULL_TH.
- oAlmostEmpty  output  1  count <= ALMOST_EMPTY_TH.
- oOverflow  output  1  one-cycle pulse: a push was dropped.
- oUnderflow  output  1  one-cycle pulse: a pop was ignored.

Behaviour:
- Reset: iReset_n low asynchronously clears the write pointer, read pointer, count, oDataOut, oValid, oOverflow and oUnderflow to 0. This gives oEmpty=1, oFull=0 and oAlmostEmpty=1. oAlmostFull=0 unless ALMOST_FULL_TH is 0, which is not a legal value.
- Memory contents are not reset. Reset mid-operation discards all stored data; the first edge after release behaves as from an empty FIFO.
- Accept rules, evaluated on the pre-edge state:
  - pop_ok = iPop & ~oEmpty.
  - push_ok = iPush & (~oFull | iPop).
  - When full, a simultaneous pop frees a slot in the same cycle.
- Write: on push_ok, mem[wptr] <= iDataIn and wptr <= wptr+1, wrapping modulo DEPTH.
- Read latency is 1 cycle. On pop_ok, oDataOut <= mem[rptr], rptr <= rptr+1 (wrapping) and oValid <= 1. Otherwise oValid <= 0 and oDataOut holds its last value.
- Read-before-write: a push and pop to the same slot in one cycle are only possible when count==DEPTH. The pop returns the old word.
- Count update:
  - push_ok & ~pop_ok: +1.
  - pop_ok & ~push_ok: -1.
  - both or neither: unchanged.
- All flags are registered and derived from the next count, so they are valid in the cycle after the causing edge.
- Empty with push and pop together: the push is accepted, the pop is ignored, and oUnderflow pulses. Count goes 0 -> 1.
- Full with push and no pop: the push is dropped, memory and wptr are unchanged, and oOverflow pulses for 1 cycle.
- Empty with pop: the pop is ignored, oUnderflow pulses, and oValid stays 0.
- Error pulses are one cycle per offending edge. Back-to-back offending edges hold the pulse high.

Decomposition:
- Shared package: the DEPTH localparam derivation, the count-width rule (ADDR_WIDTH+1), and the flag-threshold legality checks. Checks run at elaboration and report a fatal error if out of range.
- One sub-module, dual_port_ram, holds the storage: write port (we, waddr, din) and registered read port (re, raddr, dout).
- The FIFO top owns the pointers, count, flags and error logic.

Test Plan:
- Reset then fill: release reset, push 15,14,...,8 on 8 consecutive edges. Expect oCount=8, oFull=1, oAlmostFull=1 from count 6, and oAlmostEmpty=0 from count 3.
- Drain order: from full, pop 8 consecutive cycles. Expect oDataOut 15..8 with oValid=1 each cycle after the pop, then oEmpty=1 and oCount=0.
- Overflow: when full, push 63 without pop. Expect oOverflow=1 for one cycle and oCount=8. The subsequent drain must not return 63.
- Full push+pop: at count=8 with head=15, push 42 and pop together. Expect oDataOut=15, oCount stays 8, and 42 is returned last after draining.
- Empty push+pop and underflow: at count=0, push 5 with pop. Expect oUnderflow=1, oValid=0, oCount=1. A pop next cycle gives 5.
- Wrap and reset mid-operation: push and pop 20 words, sequence 0..19 interleaved. Expect in-order output across the pointer wrap. Then assert iReset_n low mid-stream: oCount=0, oEmpty=1 and oValid=0 immediately, without waiting for a clock edge.
